// File: rtl/agc_mem_pkg.sv
// Shared types and constants for the AGC data-memory sequencer.
// Optional feature macro used elsewhere in this slice: AGC_EDIT_REGS_EN.
package agc_mem_pkg;

  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 15;
  localparam int MEM_DEPTH_DEF = 2047;
  localparam int ERR_CNT_W_DEF = 8;
  localparam int ZERO_ADDR_DEF = 7;

  // Editing registers (octal 020..023)
  localparam int CYR_ADDR  = 16;
  localparam int SR_ADDR   = 17;
  localparam int CYL_ADDR  = 18;
  localparam int EDOP_ADDR = 19;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CAP  = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Bank bits are address[11:10]; only bank 00 is erasable.
  function automatic logic is_erasable(input logic [1:0] bank);
    return (bank == 2'b00);
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/agc_mem_sequencer_if.sv
// Request/response and memory-port bundle for agc_mem_sequencer.
// slave  : the sequencer itself.
// master : the environment (control unit on the req/rsp side, memory on the mem side).
// Handshake: a request transfers on a clock edge where reqValid && reqReady;
// a response transfers on an edge where rspValid && rspReady. Neither valid
// may depend on its ready, and a valid once raised holds its payload until taken.
interface agc_mem_sequencer_if #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 15,
  parameter int ERR_CNT_W = 8
);
  logic                 reqValid;
  logic                 reqReady;
  logic                 reqWrite;
  logic [ADDR_W-1:0]    reqAddr;
  logic [DATA_W-1:0]    reqData;
  logic                 rspValid;
  logic                 rspReady;
  logic [DATA_W-1:0]    rspData;
  logic                 rspErr;
  logic [ERR_CNT_W-1:0] errCount;
  logic                 memWE;
  logic [ADDR_W-1:0]    memAddr;
  logic [DATA_W-1:0]    memDataOut;
  logic [DATA_W-1:0]    memDataIn;

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqData, rspReady, memDataIn,
    output reqReady, rspValid, rspData, rspErr, errCount, memWE, memAddr, memDataOut
  );

  modport master (
    output reqValid, reqWrite, reqAddr, reqData, rspReady, memDataIn,
    input  reqReady, rspValid, rspData, rspErr, errCount, memWE, memAddr, memDataOut
  );
endinterface

// File: rtl/agc_edit_unit.sv
// Combinational editing of words written to CYR/SR/CYL/EDOP.
// Exists only when AGC_EDIT_REGS_EN is defined; other addresses pass through.
`ifdef AGC_EDIT_REGS_EN
module agc_edit_unit
  import agc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Select the edited form of the write data by target register
  always_comb begin
    dout = din;
    if (addr == ADDR_W'(CYR_ADDR)) begin
      dout = {din[0], din[DATA_W-1:1]};
    end else if (addr == ADDR_W'(SR_ADDR)) begin
      dout = {din[DATA_W-1], din[DATA_W-1:1]};
    end else if (addr == ADDR_W'(CYL_ADDR)) begin
      dout = {din[DATA_W-2:0], din[DATA_W-1]};
    end else if (addr == ADDR_W'(EDOP_ADDR)) begin
      dout      = '0;
      dout[6:0] = din[13:7];
    end
  end

endmodule
`endif

// File: rtl/agc_mem_sequencer.sv
// Initiator side of the AGC erasable/fixed data-memory port.
// Every access reads first, so a write returns the word it replaces.
// Fixed-bank writes and out-of-range addresses are rejected and counted.
// Optional feature macro: AGC_EDIT_REGS_EN (edited stores to CYR/SR/CYL/EDOP).
module agc_mem_sequencer
  import agc_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ZERO_ADDR = ZERO_ADDR_DEF,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  agc_mem_sequencer_if.slave  bus,
  output state_t              dbgState
);

  state_t                state_q, state_n;
  logic                  wr_q, wr_n;
  logic [ADDR_W-1:0]     addr_q, addr_n;
  logic [DATA_W-1:0]     data_q, data_n;
  logic [DATA_W-1:0]     g_q, g_n;
  logic                  req_ready_q, req_ready_n;
  logic                  rsp_valid_q, rsp_valid_n;
  logic                  rsp_err_q, rsp_err_n;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_n;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_n;
  logic                  mem_we_q, mem_we_n;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_n;
  logic [DATA_W-1:0]     mem_dout_q, mem_dout_n;
  logic [DATA_W-1:0]     wr_data_edit;
  logic                  req_reject;
  logic                  is_zero;

`ifdef AGC_EDIT_REGS_EN
  agc_edit_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_edit (
    .addr (addr_q),
    .din  (data_q),
    .dout (wr_data_edit)
  );
`else
  assign wr_data_edit = data_q;
`endif

  assign req_reject = !in_range(32'(bus.reqAddr), 32'(MEM_DEPTH)) ||
                      (bus.reqWrite && !is_erasable(bus.reqAddr[11:10]));
  assign is_zero    = (addr_q == ADDR_W'(ZERO_ADDR));

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n    = state_q;
    wr_n       = wr_q;
    addr_n     = addr_q;
    data_n     = data_q;
    g_n        = g_q;
    rsp_err_n  = rsp_err_q;
    rsp_data_n = rsp_data_q;
    err_cnt_n  = err_cnt_q;
    mem_we_n   = 1'b0;
    mem_addr_n = mem_addr_q;
    mem_dout_n = mem_dout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.reqValid) begin
          wr_n       = bus.reqWrite;
          addr_n     = bus.reqAddr;
          data_n     = bus.reqData;
          mem_addr_n = bus.reqAddr;
          if (req_reject) begin
            state_n    = S_RESP;
            rsp_err_n  = 1'b1;
            rsp_data_n = '0;
            g_n        = '0;
            if (err_cnt_q != '1) err_cnt_n = err_cnt_q + 1'b1;
          end else begin
            state_n   = S_ADDR;
            rsp_err_n = 1'b0;
          end
        end
      end
      S_ADDR: state_n = S_CAP;
      S_CAP: begin
        g_n = is_zero ? '0 : bus.memDataIn;
        if (wr_q) begin
          state_n    = S_WB;
          mem_we_n   = !is_zero;
          mem_dout_n = wr_data_edit;
        end else begin
          state_n    = S_RESP;
          rsp_data_n = g_n;
        end
      end
      S_WB: begin
        state_n    = S_RESP;
        rsp_data_n = g_q;
      end
      S_RESP: begin
        if (bus.rspReady) begin
          state_n   = S_IDLE;
          rsp_err_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    req_ready_n = (state_n == S_IDLE);
    rsp_valid_n = (state_n == S_RESP);
  end

  // State and registered outputs; async reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      g_q         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      err_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
    end else begin
      state_q     <= state_n;
      wr_q        <= wr_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      g_q         <= g_n;
      req_ready_q <= req_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_err_q   <= rsp_err_n;
      rsp_data_q  <= rsp_data_n;
      err_cnt_q   <= err_cnt_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_dout_q  <= mem_dout_n;
    end
  end

  assign bus.reqReady   = req_ready_q;
  assign bus.rspValid   = rsp_valid_q;
  assign bus.rspErr     = rsp_err_q;
  assign bus.rspData    = rsp_data_q;
  assign bus.errCount   = err_cnt_q;
  assign bus.memWE      = mem_we_q;
  assign bus.memAddr    = mem_addr_q;
  assign bus.memDataOut = mem_dout_q;
  assign dbgState       = state_q;

endmodule
